// File: rtl/emu_pio_bridge_if.sv
// rtl/emu_pio_bridge_if.sv - host-side parallel port bundle for emu_pio_bridge
//
// Groups the 8-bit host port of the co-emulation bridge.
//   Data_In  : host write data            (master -> slave)
//   Addr     : host byte address          (master -> slave)
//   wr_emu   : write strobe, async level  (master -> slave)
//   load_emu : commit-stimulus command    (master -> slave)
//   step_emu : DUT clock-burst command    (master -> slave)
//   get_emu  : capture command            (master -> slave)
//   Data_Out : registered read data       (slave -> master)
interface emu_pio_bridge_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        Data_In;
    logic [7:0]        Data_Out;
    logic [ADDR_W-1:0] Addr;
    logic              wr_emu;
    logic              load_emu;
    logic              step_emu;
    logic              get_emu;

    modport master (
        output Data_In, Addr, wr_emu, load_emu, step_emu, get_emu,
        input  Data_Out
    );

    modport slave (
        input  Data_In, Addr, wr_emu, load_emu, step_emu, get_emu,
        output Data_Out
    );
endinterface

// File: rtl/emu_pio_bridge.sv
// rtl/emu_pio_bridge.sv - co-emulation bridge between an 8-bit host port and an in-FPGA DUT
//
// The host fills a shadow stimulus buffer, commits it to the DUT, fires a
// programmable burst of DUT clock pulses, captures the DUT output vector and
// reads it back byte by byte. All host strobes are asynchronous levels that
// are synchronised and acted on once per rising edge.
//
// Optional feature macro: EMU_CHECKSUM_EN (running XOR checksum of captures).
//
// Ports:
//   clk_emu  : emulation clock, sole clock of the block
//   rst_n    : asynchronous active-low reset
//   host     : emu_pio_bridge_if.slave (Data_In, Data_Out, Addr, strobes)
//   dut_stim : stimulus to the DUT, byte 0 in the MSBs
//   dut_vect : DUT outputs, byte 0 in the MSBs
//   clk_dut  : generated DUT clock, registered
//   clk_LED  : copy of clk_dut
//   busy     : high while the FSM is not IDLE
//
// Host address map:
//   write 0..N_STIM-1 : shadow stimulus bytes
//   write N_STIM      : burst length step_cnt
//   write N_STIM+1    : clear sticky overrun
//   write N_STIM+2    : clear checksum (EMU_CHECKSUM_EN only)
//   read  0..N_VECT-1 : captured bytes
//   read  N_VECT      : {busy, overrun, 6'b0}
//   read  N_VECT+1    : checksum (EMU_CHECKSUM_EN only, else 8'h00)
module emu_pio_bridge #(
    parameter int N_STIM   = 4,
    parameter int N_VECT   = 3,
    parameter int ADDR_W   = 8,
    parameter int HALF_PER = 1
) (
    input  logic                clk_emu,
    input  logic                rst_n,
    emu_pio_bridge_if.slave     host,
    output logic [8*N_STIM-1:0] dut_stim,
    input  logic [8*N_VECT-1:0] dut_vect,
    output logic                clk_dut,
    output logic                clk_LED,
    output logic                busy
);

    localparam int HW = (HALF_PER > 1) ? $clog2(HALF_PER) : 1;
    localparam logic [HW-1:0]     HALF_LAST = HW'(HALF_PER - 1);
    localparam logic [ADDR_W-1:0] A_STEP    = ADDR_W'(N_STIM);
    localparam logic [ADDR_W-1:0] A_OVCLR   = ADDR_W'(N_STIM + 1);
    localparam logic [ADDR_W-1:0] A_STAT    = ADDR_W'(N_VECT);
`ifdef EMU_CHECKSUM_EN
    localparam logic [ADDR_W-1:0] A_CKCLR   = ADDR_W'(N_STIM + 2);
    localparam logic [ADDR_W-1:0] A_CKRD    = ADDR_W'(N_VECT + 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_CLK_HI = 3'd2,
        S_CLK_LO = 3'd3,
        S_CAPT   = 3'd4
    } state_t;

    state_t               state_q;
    logic [8*N_STIM-1:0]  shadow_q;
    logic [8*N_STIM-1:0]  stim_q;
    logic [8*N_VECT-1:0]  capt_q;
    logic [7:0]           step_cnt_q;
    logic [7:0]           remain_q;
    logic [HW-1:0]        half_q;
    logic                 clk_dut_q;
    logic                 overrun_q;
    logic [7:0]           data_out_q;
    logic [7:0]           rd_data_d;
    logic                 drop_d;

    // Strobe order in the vectors below: {load, step, get, wr}.
    logic [3:0] pin_d;
    logic [3:0] sync1_q;
    logic [3:0] sync2_q;
    logic [3:0] edge_q;
    logic [3:0] rise_d;

    assign pin_d = {host.load_emu, host.step_emu, host.get_emu, host.wr_emu};

    always_ff @(posedge clk_emu or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 4'b0;
            sync2_q <= 4'b0;
            edge_q  <= 4'b0;
        end else begin
            sync1_q <= pin_d;
            sync2_q <= sync1_q;
            edge_q  <= sync2_q;
        end
    end

    assign rise_d = sync2_q & ~edge_q;

`ifdef EMU_CHECKSUM_EN
    logic [7:0] cksum_q;
    logic [7:0] vect_xor_d;

    always_comb begin
        vect_xor_d = 8'h00;
        for (int k = 0; k < N_VECT; k++) begin
            vect_xor_d = vect_xor_d ^ dut_vect[8*k +: 8];
        end
    end
`endif

    // Edges that lose arbitration, or any command arriving while busy,
    // are discarded and flagged through the sticky overrun bit.
    always_comb begin
        drop_d = 1'b0;
        if (state_q == S_IDLE) begin
            if (rise_d[3])      drop_d = |rise_d[2:0];
            else if (rise_d[2]) drop_d = |rise_d[1:0];
            else if (rise_d[1]) drop_d = rise_d[0];
        end else begin
            drop_d = |rise_d[3:1];
        end
    end

    // Transfers into dut_stim and the capture buffer happen on the edge that
    // enters LOAD/CAPT, so the new data is already in place during the
    // single busy cycle those states occupy.
    always_ff @(posedge clk_emu or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            shadow_q   <= '0;
            stim_q     <= '0;
            capt_q     <= '0;
            step_cnt_q <= 8'd1;
            remain_q   <= 8'd0;
            half_q     <= '0;
            clk_dut_q  <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef EMU_CHECKSUM_EN
            cksum_q    <= 8'h00;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rise_d[3]) begin
                        stim_q  <= shadow_q;
                        state_q <= S_LOAD;
                    end else if (rise_d[2]) begin
                        if (step_cnt_q != 8'd0) begin
                            remain_q  <= step_cnt_q;
                            half_q    <= '0;
                            clk_dut_q <= 1'b1;
                            state_q   <= S_CLK_HI;
                        end
                    end else if (rise_d[1]) begin
                        capt_q  <= dut_vect;
`ifdef EMU_CHECKSUM_EN
                        cksum_q <= cksum_q ^ vect_xor_d;
`endif
                        state_q <= S_CAPT;
                    end else if (rise_d[0]) begin
                        for (int k = 0; k < N_STIM; k++) begin
                            if (host.Addr == ADDR_W'(k)) begin
                                shadow_q[8*(N_STIM-1-k) +: 8] <= host.Data_In;
                            end
                        end
                        if (host.Addr == A_STEP)  step_cnt_q <= host.Data_In;
                        if (host.Addr == A_OVCLR) overrun_q  <= 1'b0;
`ifdef EMU_CHECKSUM_EN
                        if (host.Addr == A_CKCLR) cksum_q    <= 8'h00;
`endif
                    end
                end
                S_LOAD: begin
                    state_q <= S_IDLE;
                end
                S_CAPT: begin
                    state_q <= S_IDLE;
                end
                S_CLK_HI: begin
                    if (half_q == HALF_LAST) begin
                        half_q    <= '0;
                        clk_dut_q <= 1'b0;
                        state_q   <= S_CLK_LO;
                    end else begin
                        half_q <= half_q + 1'b1;
                    end
                end
                S_CLK_LO: begin
                    if (half_q == HALF_LAST) begin
                        half_q   <= '0;
                        remain_q <= remain_q - 8'd1;
                        if (remain_q == 8'd1) begin
                            state_q <= S_IDLE;
                        end else begin
                            clk_dut_q <= 1'b1;
                            state_q   <= S_CLK_HI;
                        end
                    end else begin
                        half_q <= half_q + 1'b1;
                    end
                end
                default: begin
                    clk_dut_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase

            if (drop_d) overrun_q <= 1'b1;
        end
    end

    always_comb begin
        rd_data_d = 8'h00;
        for (int k = 0; k < N_VECT; k++) begin
            if (host.Addr == ADDR_W'(k)) begin
                rd_data_d = capt_q[8*(N_VECT-1-k) +: 8];
            end
        end
        if (host.Addr == A_STAT) rd_data_d = {busy, overrun_q, 6'b0};
`ifdef EMU_CHECKSUM_EN
        if (host.Addr == A_CKRD) rd_data_d = cksum_q;
`endif
    end

    always_ff @(posedge clk_emu or negedge rst_n) begin
        if (!rst_n) begin
            data_out_q <= 8'h00;
        end else begin
            data_out_q <= rd_data_d;
        end
    end

    assign host.Data_Out = data_out_q;
    assign dut_stim      = stim_q;
    assign clk_dut       = clk_dut_q;
    assign clk_LED       = clk_dut_q;
    assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_emu_pio_bridge.sv
// tb/tb_emu_pio_bridge.sv - self-checking bench for emu_pio_bridge
module tb_emu_pio_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] dut_stim;
    logic [23:0] dut_vect = 24'h0;
    logic        clk_dut;
    logic        clk_led;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] exp_v;
    logic [7:0] got;
    logic [7:0] cks_model = 8'h00;

    logic mon_clr = 1'b0;
    logic mon_en  = 1'b0;
    logic prev_clk = 1'b0;
    int   pulses = 0;
    int   busy_cyc = 0;
    int   led_bad = 0;

    emu_pio_bridge_if #(.ADDR_W(8)) bus ();

    emu_pio_bridge #(
        .N_STIM(4), .N_VECT(3), .ADDR_W(8), .HALF_PER(1)
    ) dut (
        .clk_emu (clk),
        .rst_n   (rst_n),
        .host    (bus),
        .dut_stim(dut_stim),
        .dut_vect(dut_vect),
        .clk_dut (clk_dut),
        .clk_LED (clk_led),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_clr) begin
            pulses   <= 0;
            busy_cyc <= 0;
            led_bad  <= 0;
            prev_clk <= 1'b0;
        end else if (mon_en) begin
            if (clk_dut && !prev_clk) pulses <= pulses + 1;
            if (busy) busy_cyc <= busy_cyc + 1;
            if (clk_led !== clk_dut) led_bad <= led_bad + 1;
            prev_clk <= clk_dut;
        end
    end

    function automatic logic [7:0] vxor(input logic [23:0] v);
        return v[23:16] ^ v[15:8] ^ v[7:0];
    endfunction

    task automatic mon_start();
        mon_en  = 1'b0;
        mon_clr = 1'b1;
        @(negedge clk);
        #1;
        mon_clr = 1'b0;
        mon_en  = 1'b1;
    endtask

    // m = {load, step, get, wr}
    task automatic pulse_cmd(input logic [3:0] m);
        @(negedge clk);
        {bus.load_emu, bus.step_emu, bus.get_emu, bus.wr_emu} = m;
        repeat (5) @(negedge clk);
        {bus.load_emu, bus.step_emu, bus.get_emu, bus.wr_emu} = 4'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic host_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.Addr    = a;
        bus.Data_In = d;
        pulse_cmd(4'b0001);
    endtask

    task automatic read_byte(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        bus.Addr = a;
        @(posedge clk);
        #1;
        d = bus.Data_Out;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        mon_en = 1'b0;
    endtask

    task automatic test_reset();
        bus.Data_In = 8'h00; bus.Addr = 8'h00;
        {bus.load_emu, bus.step_emu, bus.get_emu, bus.wr_emu} = 4'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (clk_dut !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_ctl clk_dut=%b busy=%b expected 0 0", clk_dut, busy);
        end
        checks++;
        if (dut_stim !== 32'h0) begin
            errors++; $display("FAIL reset_stim got=%h exp=00000000", dut_stim);
        end
        for (int a = 0; a < 4; a++) exp_q.push_back(8'h00);
        for (int a = 0; a < 4; a++) begin
            read_byte(8'(a), got);
            exp_v = exp_q.pop_front();
            checks++;
            if (got !== exp_v) begin
                errors++; $display("FAIL reset_read addr=%0d got=%h exp=%h", a, got, exp_v);
            end
        end
        mon_start();
        pulse_cmd(4'b0100);
        wait_idle();
        checks++;
        if (pulses != 1 || busy_cyc != 2) begin
            errors++; $display("FAIL reset_step_cnt pulses=%0d busy=%0d exp 1 2", pulses, busy_cyc);
        end
    endtask

    task automatic test_load();
        host_write(8'd0, 8'h11);
        host_write(8'd1, 8'h22);
        host_write(8'd2, 8'h33);
        host_write(8'd3, 8'h44);
        checks++;
        if (dut_stim !== 32'h0) begin
            errors++; $display("FAIL load_early got=%h exp=00000000", dut_stim);
        end
        @(negedge clk);
        bus.load_emu = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (dut_stim !== 32'h0) begin
            errors++; $display("FAIL load_latency2 got=%h exp=00000000", dut_stim);
        end
        @(negedge clk);
        checks++;
        if (dut_stim !== 32'h11223344) begin
            errors++; $display("FAIL load_latency3 got=%h exp=11223344", dut_stim);
        end
        repeat (3) @(negedge clk);
        bus.load_emu = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_step();
        host_write(8'd4, 8'd5);
        mon_start();
        pulse_cmd(4'b0100);
        wait_idle();
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL step_timeout busy=%b exp 0", busy);
        end
        checks++;
        if (pulses != 5) begin
            errors++; $display("FAIL step_pulses got=%0d exp=5", pulses);
        end
        checks++;
        if (busy_cyc != 10) begin
            errors++; $display("FAIL step_busy got=%0d exp=10", busy_cyc);
        end
        checks++;
        if (led_bad != 0 || clk_dut !== 1'b0) begin
            errors++; $display("FAIL step_led led_bad=%0d clk_dut=%b exp 0 0", led_bad, clk_dut);
        end
    endtask

    task automatic test_capture();
        dut_vect = 24'hA5B6C7;
        pulse_cmd(4'b0010);
        cks_model = cks_model ^ vxor(dut_vect);
        exp_q.push_back(8'hA5); exp_q.push_back(8'hB6); exp_q.push_back(8'hC7);
        for (int a = 0; a < 3; a++) begin
            read_byte(8'(a), got);
            exp_v = exp_q.pop_front();
            checks++;
            if (got !== exp_v) begin
                errors++; $display("FAIL capt_read addr=%0d got=%h exp=%h", a, got, exp_v);
            end
        end
    endtask

    task automatic test_overrun();
        dut_vect = 24'h010203;
        mon_start();
        @(negedge clk);
        bus.step_emu = 1'b1;
        repeat (5) @(negedge clk);
        bus.get_emu = 1'b1;
        repeat (5) @(negedge clk);
        bus.step_emu = 1'b0;
        bus.get_emu  = 1'b0;
        wait_idle();
        checks++;
        if (pulses != 5 || busy_cyc != 10) begin
            errors++; $display("FAIL ovr_burst pulses=%0d busy=%0d exp 5 10", pulses, busy_cyc);
        end
        exp_q.push_back(8'hA5); exp_q.push_back(8'hB6); exp_q.push_back(8'hC7);
        exp_q.push_back(8'h40);
        for (int a = 0; a < 4; a++) begin
            read_byte(8'(a), got);
            exp_v = exp_q.pop_front();
            checks++;
            if (got !== exp_v) begin
                errors++; $display("FAIL ovr_read addr=%0d got=%h exp=%h", a, got, exp_v);
            end
        end
        host_write(8'd5, 8'h5A);
        exp_q.push_back(8'h00);
        read_byte(8'd3, got);
        exp_v = exp_q.pop_front();
        checks++;
        if (got !== exp_v) begin
            errors++; $display("FAIL ovr_clear got=%h exp=%h", got, exp_v);
        end
    endtask

    task automatic test_back_to_back();
        host_write(8'd0, 8'hAA);
        host_write(8'd7, 8'hFF);
        dut_vect = 24'h000000;
        pulse_cmd(4'b1010);
        checks++;
        if (dut_stim !== 32'hAA223344) begin
            errors++; $display("FAIL prio_load got=%h exp=aa223344", dut_stim);
        end
        exp_q.push_back(8'hA5); exp_q.push_back(8'hB6); exp_q.push_back(8'hC7);
        exp_q.push_back(8'h40); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        for (int a = 0; a < 4; a++) begin
            read_byte(8'(a), got);
            exp_v = exp_q.pop_front();
            checks++;
            if (got !== exp_v) begin
                errors++; $display("FAIL prio_read addr=%0d got=%h exp=%h", a, got, exp_v);
            end
        end
        host_write(8'd5, 8'h00);
        read_byte(8'd3, got);
        exp_v = exp_q.pop_front();
        checks++;
        if (got !== exp_v) begin
            errors++; $display("FAIL prio_clear got=%h exp=%h", got, exp_v);
        end
        read_byte(8'd9, got);
        exp_v = exp_q.pop_front();
        checks++;
        if (got !== exp_v) begin
            errors++; $display("FAIL unmapped_read got=%h exp=%h", got, exp_v);
        end
        host_write(8'd4, 8'd0);
        mon_start();
        pulse_cmd(4'b0100);
        wait_idle();
        checks++;
        if (pulses != 0 || busy_cyc != 0) begin
            errors++; $display("FAIL step_zero pulses=%0d busy=%0d exp 0 0", pulses, busy_cyc);
        end
    endtask

    task automatic test_checksum();
`ifdef EMU_CHECKSUM_EN
        host_write(8'd6, 8'h00);
        cks_model = 8'h00;
        dut_vect = 24'hA5B6C7;
        pulse_cmd(4'b0010);
        cks_model = cks_model ^ vxor(dut_vect);
        dut_vect = 24'h010203;
        pulse_cmd(4'b0010);
        cks_model = cks_model ^ vxor(dut_vect);
        exp_q.push_back(cks_model);
        read_byte(8'd4, got);
        exp_v = exp_q.pop_front();
        checks++;
        if (got !== exp_v) begin
            errors++; $display("FAIL cksum_read got=%h exp=%h", got, exp_v);
        end
        host_write(8'd6, 8'h33);
        exp_q.push_back(8'h00);
        read_byte(8'd4, got);
        exp_v = exp_q.pop_front();
        checks++;
        if (got !== exp_v) begin
            errors++; $display("FAIL cksum_clear got=%h exp=%h", got, exp_v);
        end
`else
        dut_vect = 24'h010203;
        pulse_cmd(4'b0010);
        host_write(8'd6, 8'h33);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h01);
        read_byte(8'd4, got);
        exp_v = exp_q.pop_front();
        checks++;
        if (got !== exp_v) begin
            errors++; $display("FAIL nocksum_read got=%h exp=%h", got, exp_v);
        end
        read_byte(8'd0, got);
        exp_v = exp_q.pop_front();
        checks++;
        if (got !== exp_v) begin
            errors++; $display("FAIL nocksum_capt got=%h exp=%h", got, exp_v);
        end
`endif
    endtask

    task automatic test_reset_mid_burst();
        host_write(8'd4, 8'd5);
        @(negedge clk);
        bus.step_emu = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (clk_dut) break;
            @(negedge clk);
        end
        checks++;
        if (clk_dut !== 1'b1) begin
            errors++; $display("FAIL midrst_start clk_dut=%b exp 1", clk_dut);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (clk_dut !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL midrst_async clk_dut=%b busy=%b exp 0 0", clk_dut, busy);
        end
        bus.step_emu = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        mon_start();
        pulse_cmd(4'b0100);
        wait_idle();
        checks++;
        if (pulses != 1 || busy_cyc != 2) begin
            errors++; $display("FAIL midrst_step_cnt pulses=%0d busy=%0d exp 1 2", pulses, busy_cyc);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_step();
        test_capture();
        test_overrun();
        test_back_to_back();
        test_checksum();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
